// File: rtl/fip_pkg.sv
// rtl/fip_pkg.sv - Q16.16 fixed-point types, constants and batch FSM states
package fip_pkg;
  typedef logic signed [31:0] fip;
  typedef logic signed [63:0] fip_wide;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh8000_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;
  localparam int INTER_LAT_DEFAULT = 52;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_ABORT} batch_state_e;

  function automatic fip_wide fip_mul(input fip_wide a, input fip_wide b);
    return (a * b) >>> 16;
  endfunction
endpackage

// File: rtl/intersection.sv
// rtl/intersection.sv - pipelined Moller-Trumbore ray/triangle test, fixed LAT cycles en->valid
module intersection
  import fip_pkg::*;
#(
  parameter int LAT = INTER_LAT_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [191:0] i_ray,
  input  logic [287:0] i_tri,
  output logic         o_valid,
  output logic         o_result,
  output logic [31:0]  o_t
);
  fip_wide org [3];
  fip_wide dir [3];
  fip_wide v0  [3];
  fip_wide e1  [3];
  fip_wide e2  [3];
  fip_wide s   [3];
  fip_wide p   [3];
  fip_wide q   [3];
  fip_wide det, u, v, num, t_wide;
  logic    hit;

  logic vld_q [LAT];
  logic res_q [LAT];
  fip   t_q   [LAT];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      org[k] = fip_wide'($signed(i_ray[32*k +: 32]));
      dir[k] = fip_wide'($signed(i_ray[96+32*k +: 32]));
      v0[k]  = fip_wide'($signed(i_tri[32*k +: 32]));
      e1[k]  = fip_wide'($signed(i_tri[96+32*k +: 32])) - v0[k];
      e2[k]  = fip_wide'($signed(i_tri[192+32*k +: 32])) - v0[k];
      s[k]   = org[k] - v0[k];
    end
    p[0] = fip_mul(dir[1], e2[2]) - fip_mul(dir[2], e2[1]);
    p[1] = fip_mul(dir[2], e2[0]) - fip_mul(dir[0], e2[2]);
    p[2] = fip_mul(dir[0], e2[1]) - fip_mul(dir[1], e2[0]);
    q[0] = fip_mul(s[1], e1[2]) - fip_mul(s[2], e1[1]);
    q[1] = fip_mul(s[2], e1[0]) - fip_mul(s[0], e1[2]);
    q[2] = fip_mul(s[0], e1[1]) - fip_mul(s[1], e1[0]);
    det  = fip_mul(e1[0], p[0]) + fip_mul(e1[1], p[1]) + fip_mul(e1[2], p[2]);
    u    = fip_mul(s[0], p[0]) + fip_mul(s[1], p[1]) + fip_mul(s[2], p[2]);
    v    = fip_mul(dir[0], q[0]) + fip_mul(dir[1], q[1]) + fip_mul(dir[2], q[2]);
    num  = fip_mul(e2[0], q[0]) + fip_mul(e2[1], q[1]) + fip_mul(e2[2], q[2]);
    // Fold the determinant sign into the operands so one set of range tests covers both windings.
    if (det < 0) begin
      det = -det;
      u   = -u;
      v   = -v;
      num = -num;
    end
    t_wide = (det == 0) ? '0 : (num * fip_wide'(FIP_ONE)) / det;
    hit = (det > 0) && (u >= 0) && (v >= 0) && (u + v <= det) &&
          (t_wide >= fip_wide'(FIP_MIN)) && (t_wide <= fip_wide'(FIP_MAX));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < LAT; k++) begin
        vld_q[k] <= 1'b0;
        res_q[k] <= 1'b0;
        t_q[k]   <= '0;
      end
    end else begin
      vld_q[0] <= i_en;
      res_q[0] <= hit;
      t_q[0]   <= t_wide[31:0];
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
        t_q[k]   <= t_q[k-1];
      end
    end
  end

  assign o_valid  = vld_q[LAT-1];
  assign o_result = res_q[LAT-1];
  assign o_t      = t_q[LAT-1];
endmodule

// File: rtl/multi_ray_tri_insector_tracker.sv
// rtl/multi_ray_tri_insector_tracker.sv - per-ray closest-hit registers (ray_min_tracker)
module ray_min_tracker
  import fip_pkg::*;
#(
  parameter int IDX_W = 32,
  parameter fip MIN_T = 32'sh0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_result,
  input  logic [31:0]      i_t,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_hit,
  output logic [31:0]      o_t,
  output logic [IDX_W-1:0] o_idx
);
  logic             hit_q, hit_d;
  fip               t_q, t_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             take;

  // Strict less-than keeps the earlier (lower) index on equal t.
  assign take = i_valid && i_result && ($signed(i_t) >= MIN_T) && ($signed(i_t) < t_q);

  always_comb begin
    hit_d = hit_q;
    t_d   = t_q;
    idx_d = idx_q;
    if (i_clear) begin
      hit_d = 1'b0;
      t_d   = FIP_MAX;
    end else if (take) begin
      hit_d = 1'b1;
      t_d   = $signed(i_t);
      idx_d = i_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hit_q <= 1'b0;
      t_q   <= FIP_MAX;
      idx_q <= '0;
    end else begin
      hit_q <= hit_d;
      t_q   <= t_d;
      idx_q <= idx_d;
    end
  end

  assign o_hit = hit_q;
  assign o_t   = t_q;
  assign o_idx = idx_q;
endmodule

// File: rtl/multi_ray_tri_insector.sv
// rtl/multi_ray_tri_insector.sv - batch FSM, counters and triangle stream feeding NRAYS lanes
module multi_ray_tri_insector
  import fip_pkg::*;
#(
  parameter int NRAYS     = 4,
  parameter int IDX_W     = 32,
  parameter fip MIN_T     = 32'sh0,
  parameter int INTER_LAT = INTER_LAT_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NRAYS*192-1:0]   i_rays,
  input  logic [IDX_W-1:0]       i_tri_cnt,
  input  logic [287:0]           i_tri,
  input  logic                   i_tri_valid,
  output logic                   o_tri_ready,
  output logic [NRAYS-1:0]       o_hit,
  output logic [NRAYS*32-1:0]    o_t,
  output logic [NRAYS*IDX_W-1:0] o_idx,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted
);
  batch_state_e           state_q;
  logic [NRAYS*192-1:0]   rays_q;
  logic [IDX_W-1:0]       cnt_q, in_cnt_q, out_cnt_q, inflight_q;
  logic                   done_q, aborted_q;
  logic [NRAYS-1:0]       lane_vld, lane_res;
  logic [NRAYS*32-1:0]    lane_t;
  logic                   accept, lane_valid, upd_en, start_acc;

  assign o_tri_ready = (state_q == ST_RUN) && (in_cnt_q < cnt_q);
  assign accept      = i_tri_valid && o_tri_ready;
  // All lanes share one pipeline schedule, so their valids always coincide.
  assign lane_valid  = &lane_vld;
  assign upd_en      = lane_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign start_acc   = (state_q == ST_IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      rays_q     <= '0;
      cnt_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (accept) in_cnt_q <= in_cnt_q + 1'b1;
      if (upd_en) out_cnt_q <= out_cnt_q + 1'b1;
      case ({accept, lane_valid})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: ;
      endcase
      case (state_q)
        ST_IDLE: if (start_acc) begin
          rays_q     <= i_rays;
          cnt_q      <= i_tri_cnt;
          in_cnt_q   <= '0;
          out_cnt_q  <= '0;
          inflight_q <= '0;
          state_q    <= ST_RUN;
        end
        ST_RUN: begin
          if (i_abort) state_q <= ST_ABORT;
          else if (in_cnt_q == cnt_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (i_abort) state_q <= ST_ABORT;
          else if (out_cnt_q == cnt_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        ST_ABORT: if (inflight_q == '0) begin
          state_q   <= ST_IDLE;
          aborted_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NRAYS; g++) begin : g_lane
    intersection #(.LAT(INTER_LAT)) u_lane (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_en     (accept),
      .i_ray    (rays_q[192*g +: 192]),
      .i_tri    (i_tri),
      .o_valid  (lane_vld[g]),
      .o_result (lane_res[g]),
      .o_t      (lane_t[32*g +: 32])
    );

    ray_min_tracker #(.IDX_W(IDX_W), .MIN_T(MIN_T)) u_trk (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_clear  (start_acc),
      .i_valid  (upd_en),
      .i_result (lane_res[g]),
      .i_t      (lane_t[32*g +: 32]),
      .i_idx    (out_cnt_q),
      .o_hit    (o_hit[g]),
      .o_t      (o_t[32*g +: 32]),
      .o_idx    (o_idx[IDX_W*g +: IDX_W])
    );
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_aborted = aborted_q;
endmodule

// File: tb/tb_multi_ray_tri_insector.sv
// tb/tb_multi_ray_tri_insector.sv - directed table and sequence bench for multi_ray_tri_insector
module tb_multi_ray_tri_insector;
  localparam int NR  = 2;
  localparam int IW  = 32;
  localparam int LAT = 52;
  localparam logic [31:0] TMAX = 32'h7fff_ffff;

  logic           clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, tri_valid = 1'b0;
  logic [NR*192-1:0] rays = '0;
  logic [IW-1:0]  tri_cnt = '0;
  logic [287:0]   tri_d = '0;
  logic           rdy, busy, done, aborted, m_rdy, m_busy, m_done, m_aborted;
  logic [NR-1:0]  hit, m_hit;
  logic [NR*32-1:0] t_o, m_t;
  logic [NR*IW-1:0] idx_o, m_idx;

  multi_ray_tri_insector #(.NRAYS(NR), .IDX_W(IW), .MIN_T(32'sh0), .INTER_LAT(LAT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort), .i_rays(rays),
    .i_tri_cnt(tri_cnt), .i_tri(tri_d), .i_tri_valid(tri_valid), .o_tri_ready(rdy),
    .o_hit(hit), .o_t(t_o), .o_idx(idx_o), .o_busy(busy), .o_done(done), .o_aborted(aborted));

  multi_ray_tri_insector #(.NRAYS(NR), .IDX_W(IW), .MIN_T(32'sh0000_8000), .INTER_LAT(LAT)) dut_mt (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort), .i_rays(rays),
    .i_tri_cnt(tri_cnt), .i_tri(tri_d), .i_tri_valid(tri_valid), .o_tri_ready(m_rdy),
    .o_hit(m_hit), .o_t(m_t), .o_idx(m_idx), .o_busy(m_busy), .o_done(m_done), .o_aborted(m_aborted));

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          gap;
    int          pos [6];
    logic [31:0] z [6];
    logic [1:0]  hit;
    logic [31:0] t0;
    int          idx0;
    logic [31:0] t1;
    int          idx1;
    logic [1:0]  mt_hit;
  } vec_t;

  vec_t vecs [6];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pos 0 centres the triangle on ray0 (0,0), pos 1 on ray1 (10,10), pos 2 on neither
  function automatic logic [287:0] mk_tri(input int pos, input logic [31:0] z);
    int c;
    logic [287:0] r;
    c = (pos == 0) ? 0 : (pos == 1) ? 10 : 50;
    r[31:0]    = 32'((c - 1) * 65536);
    r[63:32]   = 32'((c - 1) * 65536);
    r[95:64]   = z;
    r[127:96]  = 32'((c + 3) * 65536);
    r[159:128] = 32'((c - 1) * 65536);
    r[191:160] = z;
    r[223:192] = 32'((c - 1) * 65536);
    r[255:224] = 32'((c + 3) * 65536);
    r[287:256] = z;
    return r;
  endfunction

  task automatic send(input int n, input int gap, input vec_t v, input logic same_tri);
    int sent, cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 200) begin
      tri_d     = same_tri ? mk_tri(0, 32'h0001_0000) : mk_tri(v.pos[sent], v.z[sent]);
      tri_valid = ((cyc % (gap + 1)) == 0);
      @(negedge clk);
      acc = tri_valid && rdy;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    tri_valid = 1'b0;
    chk("accepted_count", 64'(sent), 64'(n));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int dones;
    @(negedge clk);
    start   = 1'b1;
    tri_cnt = IW'(v.cnt);
    @(posedge clk);
    #1 start = 1'b0;
    chk($sformatf("v%0d_busy", id), 64'(busy), 64'd1);
    send(v.cnt, v.gap, v, 1'b0);
    chk($sformatf("v%0d_ready_fall", id), 64'(rdy), 64'd0);
    dones = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk($sformatf("v%0d_done_pulses", id), 64'(dones), 64'd1);
    chk($sformatf("v%0d_hit", id), 64'(hit), 64'(v.hit));
    chk($sformatf("v%0d_t0", id), 64'(t_o[31:0]), 64'(v.t0));
    chk($sformatf("v%0d_t1", id), 64'(t_o[63:32]), 64'(v.t1));
    if (v.hit[0]) chk($sformatf("v%0d_idx0", id), 64'(idx_o[31:0]), 64'(v.idx0));
    if (v.hit[1]) chk($sformatf("v%0d_idx1", id), 64'(idx_o[63:32]), 64'(v.idx1));
    chk($sformatf("v%0d_mint_hit", id), 64'(m_hit), 64'(v.mt_hit));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected end");
    $fatal(1);
  end

  initial begin
    int dones, abs, done_at;
    logic rdy_seen;
    vec_t v;

    vecs[0] = '{3, 0, '{2, 0, 0, 0, 0, 0},
                '{32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0},
                2'b01, 32'h0001_0000, 2, TMAX, 0, 2'b01};
    vecs[1] = '{4, 0, '{0, 1, 2, 0, 0, 0},
                '{32'h0003_0000, 32'h0005_0000, 32'h0001_0000, 32'h0003_0000, 32'h0, 32'h0},
                2'b11, 32'h0003_0000, 0, 32'h0005_0000, 1, 2'b11};
    vecs[2] = '{1, 0, '{0, 0, 0, 0, 0, 0},
                '{32'h0000_4000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                2'b01, 32'h0000_4000, 0, TMAX, 0, 2'b00};
    vecs[3] = '{3, 0, '{0, 1, 0, 0, 0, 0},
                '{32'hffff_0000, 32'h0, 32'h0007_0000, 32'h0, 32'h0, 32'h0},
                2'b11, 32'h0007_0000, 2, 32'h0, 1, 2'b01};
    vecs[4] = '{5, 2, '{0, 1, 0, 1, 0, 0},
                '{32'h0004_0000, 32'h0002_0000, 32'h0003_0000, 32'h0002_0000, 32'h0006_0000, 32'h0},
                2'b11, 32'h0003_0000, 2, 32'h0002_0000, 1, 2'b11};
    vecs[5] = vecs[4];
    vecs[5].gap = 0;

    rays[191:160] = 32'h0001_0000;
    rays[223:192] = 32'h000a_0000;
    rays[255:224] = 32'h000a_0000;
    rays[383:352] = 32'h0001_0000;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(rdy), 64'd0);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_t", 64'(t_o), {TMAX, TMAX});
    chk("rst_idx", 64'(idx_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      run_vec(v, i);
    end

    // Empty batch, with a simultaneous abort that start must override.
    @(negedge clk);
    start   = 1'b1;
    abort   = 1'b1;
    tri_cnt = '0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    rdy_seen = rdy;
    done_at  = -1;
    abs      = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (rdy) rdy_seen = 1'b1;
      if (aborted) abs++;
      if (done && done_at < 0) done_at = c;
    end
    chk("cnt0_done_cycle", 64'(done_at), 64'd2);
    chk("cnt0_ready_seen", 64'(rdy_seen), 64'd0);
    chk("cnt0_aborted", 64'(abs), 64'd0);
    chk("cnt0_hit", 64'(hit), 64'd0);

    // Abort after 4 of 10 accepts; a start during ABORT must be ignored.
    @(negedge clk);
    start   = 1'b1;
    tri_cnt = IW'(10);
    @(posedge clk);
    #1 start = 1'b0;
    send(4, 0, vecs[0], 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b1;
    chk("abort_ready", 64'(rdy), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    abs   = 0;
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (aborted) abs++;
    end
    chk("abort_pulses", 64'(abs), 64'd1);
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_hit", 64'(hit), 64'd0);
    chk("abort_t0", 64'(t_o[31:0]), 64'(TMAX));
    chk("abort_idle", 64'(busy), 64'd0);

    // Abort while idle is ignored.
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    abs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (aborted || busy) abs++;
    end
    chk("idle_abort_ignored", 64'(abs), 64'd0);

    v = vecs[0];
    run_vec(v, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_ray_tri_insector.md
# multi_ray_tri_insector

Batch triangle-intersection engine that tests one stream of triangles against `NRAYS` rays in parallel and keeps, per ray, the closest valid hit (`t`, triangle index). It sits between the triangle fetch path and the shading/scheduler logic. Triangles arrive on a valid/ready stream, so memory access is decoupled from intersection. It adds a `MIN_T` threshold, ascending index tagging, deterministic tie-break and batch abort.

## Interface
Parameters:
- `NRAYS`, 4: number of rays (lanes) per batch; ≥1.
- `IDX_W`, 32: triangle index/count width.
- `MIN_T`, 32'sh0: minimum accepted `t` (signed Q16.16); hits with `t < MIN_T` are discarded.
- `INTER_LAT`, 52: fixed latency, in cycles, of one intersection lane from `i_en` to `o_valid`.

Ports:
- `i_clk`, in, 1: clock.
- `i_rstn`, in, 1: reset; synchronous, active-low.
- `i_start`, in, 1: batch start pulse; accepted only in IDLE.
- `i_abort`, in, 1: abort current batch; honoured in RUN/DRAIN.
- `i_rays`, in, NRAYS*192: ray k at bits [192k+191:192k]; per ray, origin xyz then direction xyz, 32b Q16.16 each; sampled on accepted `i_start`.
- `i_tri_cnt`, in, IDX_W: triangles in batch; sampled on accepted `i_start`.
- `i_tri`, in, 288: v0 xyz, v1 xyz, v2 xyz, 32b each, LSB-first.
- `i_tri_valid`, in, 1: `i_tri` valid.
- `o_tri_ready`, out, 1: engine accepts a triangle this cycle.
- `o_hit`, out, NRAYS: per-ray any-hit flag.
- `o_t`, out, NRAYS*32: per-ray minimum `t`.
- `o_idx`, out, NRAYS*IDX_W: per-ray index of the closest triangle.
- `o_busy`, out, 1: state ≠ IDLE.
- `o_done`, out, 1: one-cycle pulse when a batch completes normally.
- `o_aborted`, out, 1: one-cycle pulse when an abort completes.

## Operation
- States: IDLE, RUN, DRAIN, ABORT.
- IDLE → RUN on `i_start`. Start latches rays and count, clears `o_hit`, sets every `o_t` to 32'sh7fffffff and clears `in_cnt`, `out_cnt` and `inflight`.
- RUN: `o_tri_ready = (in_cnt < cnt)`. A triangle is accepted when `i_tri_valid && o_tri_ready`; this broadcasts it to all NRAYS intersection lanes and increments `in_cnt`. RUN → DRAIN when `in_cnt == cnt`, including the `cnt == 0` case, where RUN is entered and left the next cycle.
- Results come back in order. Each lane `o_valid` tags its result with index `out_cnt`, then `out_cnt++`.
- Per lane update condition: `result && t >= MIN_T && t < cur_t` (signed, strict). On update: `cur_t ← t`, `idx ← out_cnt`, `hit ← 1`. On equal `t` the lower index wins.
- DRAIN → IDLE with `o_done` when `out_cnt == cnt` (same cycle as the last update registers). `cnt == 0` gives DRAIN then `o_done` with no hits.
- `i_abort` in RUN/DRAIN → ABORT. `o_tri_ready` drops to 0 and lane results are discarded. ABORT waits for `inflight == 0` (increment on accept, decrement on lane valid), then → IDLE with `o_aborted` pulse. Per-ray outputs are left as they were.
- `i_start` outside IDLE is ignored. `i_abort` in IDLE/ABORT is ignored. `i_start` and `i_abort` together in IDLE: start wins.

## Timing
- Reset: state IDLE; `o_tri_ready` 0; `o_hit` 0; `o_t` 32'sh7fffffff all lanes; `o_idx` 0; `o_busy` 0; `o_done` 0; `o_aborted` 0; all counters 0.
- Reset mid-batch discards everything. Lane pipelines are reset through their `i_rstn`.
- Throughput: one triangle per cycle.
- Latency: accept → lane valid = INTER_LAT; lane valid → registered `o_t`/`o_idx` = 1 cycle.
- `o_done` fires 1 cycle after the last lane valid. Minimum batch time is `cnt + INTER_LAT + 2` cycles.
- Outputs are stable while IDLE and valid from `o_done` until the next accepted start.
- Accept and lane-valid in the same cycle leave `inflight` unchanged.

## Structure
- Shared package `fip_pkg`: typedef `fip`, constants `FIP_ONE`, `FIP_MIN`, `FIP_MAX`, `INTER_LAT_DEFAULT`.
- Generate NRAYS instances of the existing pipelined `intersection`.
- One sub-module, `ray_min_tracker`: per-lane registers for `cur_t`, `idx` and `hit`, with the compare/update logic.
- The top level holds the FSM, counters and stream handshake.

## Test plan
- NRAYS=2, cnt=3. Ray0 hits tri1 at t=0x00020000 and tri2 at t=0x00010000; ray1 hits nothing. Required: `o_done` once, `o_hit`=01, ray0 `o_t`=0x00010000, ray0 `o_idx`=2, ray1 `o_t`=0x7fffffff.
- Tie: tri0 and tri3 both at t=0x00030000. Required: `o_idx`=0.
- MIN_T=0x00008000, only hit at t=0x00004000. Required: `o_hit`=0.
- cnt=0. Required: `o_done` 2 cycles after start, `o_tri_ready` never high.
- Bursty `i_tri_valid` (1 of 3 cycles), cnt=5. Result matches the continuous run. `o_tri_ready` falls after the 5th accept.
- Abort after 4 of 10 accepts. Required: `o_tri_ready`=0, `o_aborted` pulse after the 4 in-flight results drain, no `o_done`. A following batch runs correctly.
